// File: rtl/block_scaling_unit.sv
// Block-floating-point front end: buffers BLOCK_SIZE samples, derives a clamped
// ceil(peak / 2^SF_SHIFT) scaling factor, then replays the block with that factor.
module block_scaling_unit #(
  parameter int DATA_W     = 32,
  parameter int SF_W       = 12,
  parameter int BLOCK_SIZE = 1024,
  parameter int MAX_SF     = 4095,
  parameter int SF_SHIFT   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SF_W-1:0]   out_sf,
  output logic              out_first,
  output logic              out_last,
  output logic              busy
);

  localparam int AW = $clog2(BLOCK_SIZE);
  localparam int QW = DATA_W + 1 - SF_SHIFT;
  localparam logic [AW:0]     BS_CNT = (AW+1)'(BLOCK_SIZE);
  localparam logic [DATA_W:0] ROUND  = (DATA_W+1)'((64'd1 << SF_SHIFT) - 64'd1);

  typedef enum logic [1:0] {FILL, CALC, DRAIN} state_t;

  state_t              state, state_nx;
  logic [AW:0]         wr_cnt, rd_cnt;
  logic [DATA_W-2:0]   peak, mag;
  logic [DATA_W-1:0]   neg;
  logic [DATA_W-1:0]   mem [BLOCK_SIZE];
  logic                started;
  logic                in_xfer, out_xfer, load;
  logic [DATA_W:0]     sum;
  logic [QW-1:0]       quo;
  logic [SF_W-1:0]     sf;

  assign in_ready = (state == FILL) && started;
  assign busy     = (state != FILL);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign load     = (state == DRAIN) && (rd_cnt != BS_CNT) && (!out_valid || out_ready);

  // |x| with the most negative value saturating to the largest positive magnitude
  always_comb begin
    neg = '0 - in_data;
    if (!in_data[DATA_W-1])
      mag = in_data[DATA_W-2:0];
    else if (neg[DATA_W-1])
      mag = '1;
    else
      mag = neg[DATA_W-2:0];
  end

  always_comb begin
    sum = {2'b00, peak} + ROUND;
    quo = sum[DATA_W:SF_SHIFT];
    if (quo == '0)
      sf = SF_W'(1);
    else if (quo > QW'(MAX_SF))
      sf = SF_W'(MAX_SF);
    else
      sf = quo[SF_W-1:0];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FILL:  if (in_xfer && (wr_cnt == BS_CNT - 1'b1)) state_nx = CALC;
      CALC:  state_nx = DRAIN;
      DRAIN: if (out_xfer && out_last) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (in_xfer) mem[wr_cnt[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      peak      <= '0;
      out_sf    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      started <= 1'b1;
      unique case (state)
        FILL: begin
          if (in_xfer) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (mag > peak) peak <= mag;
          end
        end
        CALC: begin
          out_sf <= sf;
          rd_cnt <= '0;
        end
        DRAIN: begin
          // The synchronous read lands directly in the output register, so a
          // new read is only issued when the current sample has been taken.
          if (load) begin
            out_valid <= 1'b1;
            out_data  <= mem[rd_cnt[AW-1:0]];
            out_first <= (rd_cnt == '0);
            out_last  <= (rd_cnt == BS_CNT - 1'b1);
            rd_cnt    <= rd_cnt + 1'b1;
          end else if (out_xfer && out_last) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            peak      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_block_scaling_unit.sv
// Randomised self-checking bench for block_scaling_unit with a block-level
// reference model (peak magnitude -> ceil division -> clamp) and an ordered scoreboard.
module tb_block_scaling_unit;

  localparam int BS = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] out_sf;
  logic        out_first;
  logic        out_last;
  logic        busy;

  logic [31:0] blk [BS];
  int          n_checks = 0;
  int          n_errs = 0;
  int          cyc = 0;
  int          t_last = 0;
  bit          drv_done = 1'b0;
  logic [11:0] last_sf = '0;

  block_scaling_unit #(
    .DATA_W(32), .SF_W(12), .BLOCK_SIZE(BS), .MAX_SF(4095), .SF_SHIFT(19)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sf(out_sf), .out_first(out_first), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int ref_sf();
    longint pk = 0;
    longint m;
    longint q;
    for (int i = 0; i < BS; i++) begin
      m = longint'($signed(blk[i]));
      if (m < 0) m = -m;
      if (m > 64'sd2147483647) m = 64'sd2147483647;
      if (m > pk) pk = m;
    end
    q = (pk + 524287) / 524288;
    if (q < 1) q = 1;
    if (q > 4095) q = 4095;
    return int'(q);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sf", out_sf, 0);
    check("rst_first_last", {out_first, out_last}, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1);
    last_sf = '0;
  endtask

  task automatic drive_samples(input int n, input int gap);
    int  i = 0;
    int  guard = 0;
    bit  sf_seen = 1'b0;
    while (i < n) begin
      @(negedge clk);
      if (++guard > 40000) begin
        check("in_timeout", 0, 1);
        break;
      end
      if (!sf_seen && i >= n / 2) begin
        sf_seen = 1'b1;
        check("sf_hold_fill", out_sf, last_sf);
      end
      if ($urandom_range(99) < gap) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data = blk[i];
        if (in_ready) begin
          i++;
          t_last = cyc + 1;
        end
      end
    end
    drv_done = 1'b1;
  endtask

  task automatic collect(input int exp_sf, input int rdy);
    int          idx = 0;
    int          guard = 0;
    bit          stalled = 1'b0;
    bit          seen = 1'b0;
    logic [31:0] hd = '0;
    logic        hf = 1'b0;
    logic        hl = 1'b0;
    while (idx < BS) begin
      @(negedge clk);
      if (++guard > 60000) begin
        check("out_timeout", 0, 1);
        break;
      end
      if (drv_done && cyc >= t_last) begin
        check("in_ready_busy", in_ready, 0);
        check("busy_high", busy, 1);
        in_valid = 1'($urandom_range(1));
        in_data = $urandom;
      end
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, hd);
        check("stall_first", out_first, hf);
        check("stall_last", out_last, hl);
      end
      stalled = 1'b0;
      out_ready = ($urandom_range(99) < rdy);
      if (out_valid) begin
        if (!seen) begin
          seen = 1'b1;
          check("first_latency", 64'(cyc - t_last), 64'(2));
        end
        if (out_ready) begin
          check("data", out_data, blk[idx]);
          check("first", out_first, (idx == 0));
          check("last", out_last, (idx == BS - 1));
          check("sf", out_sf, exp_sf);
          idx++;
        end else begin
          stalled = 1'b1;
          hd = out_data;
          hf = out_first;
          hl = out_last;
        end
      end
    end
  endtask

  task automatic run_block(input int gap, input int rdy);
    int exp_sf;
    exp_sf = ref_sf();
    t_last = -1000000;
    drv_done = 1'b0;
    fork
      drive_samples(BS, gap);
      collect(exp_sf, rdy);
    join
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("in_ready_back", in_ready, 1);
    check("valid_after_last", out_valid, 0);
    check("busy_after_last", busy, 0);
    check("sf_after_last", out_sf, exp_sf);
    last_sf = 12'(exp_sf);
  endtask

  task automatic zero_block();
    for (int i = 0; i < BS; i++) blk[i] = '0;
  endtask

  task automatic small_block(input int lim);
    for (int i = 0; i < BS; i++) blk[i] = 32'($urandom_range(2 * lim) - lim);
  endtask

  initial begin
    logic [31:0] spikes [4];
    spikes[0] = 32'd524288;
    spikes[1] = 32'd524289;
    spikes[2] = 32'(-1000000);
    spikes[3] = 32'h4000_0000;

    do_reset();

    for (int i = 0; i < BS; i++) blk[i] = 32'(i);
    run_block(0, 100);

    for (int k = 0; k < 4; k++) begin
      zero_block();
      blk[$urandom_range(BS - 1)] = spikes[k];
      run_block(0, 100);
    end

    zero_block();
    run_block(0, 100);
    zero_block();
    blk[$urandom_range(BS - 1)] = 32'h8000_0000;
    run_block(0, 100);
    zero_block();
    blk[$urandom_range(BS - 1)] = 32'h7fff_ffff;
    run_block(0, 100);

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < BS; i++) blk[i] = $urandom;
      run_block(30, 50);
    end

    small_block(1000);
    drive_samples(500, 20);
    do_reset();
    small_block(1000);
    blk[$urandom_range(BS - 1)] = 32'd1572864;
    run_block(0, 100);

    small_block(99);
    blk[$urandom_range(BS - 1)] = 32'(-100);
    run_block(0, 100);
    small_block(5000);
    blk[$urandom_range(BS - 1)] = 32'h7fff_ffff;
    run_block(10, 80);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
